// File: rtl/scc_pkg.sv
// Shared constants and types for the SCC special-register bank.
package scc_pkg;

  localparam int unsigned REG_IDX_W = 3;
  localparam int unsigned NUM_FLAGS = 4;

  localparam logic [REG_IDX_W-1:0] REG_ZR   = 3'd0;
  localparam logic [REG_IDX_W-1:0] REG_R1   = 3'd1;
  localparam logic [REG_IDX_W-1:0] REG_R2   = 3'd2;
  localparam logic [REG_IDX_W-1:0] REG_R3   = 3'd3;
  localparam logic [REG_IDX_W-1:0] REG_SP   = 3'd4;
  localparam logic [REG_IDX_W-1:0] REG_LR   = 3'd5;
  localparam logic [REG_IDX_W-1:0] REG_PC   = 3'd6;
  localparam logic [REG_IDX_W-1:0] REG_CPSR = 3'd7;

  // Bit positions inside a {N,Z,C,V} flags vector.
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef logic [NUM_FLAGS-1:0] flags_t;

endpackage

// File: rtl/special_reg_bank_sp_ctrl.sv
// Stack pointer with push/pop, bound checking and a sticky error flag.
module sp_ctrl #(
  parameter int unsigned       DATA_W   = 32,
  parameter logic [DATA_W-1:0] SP_RESET = 32'h0000_FFFF,
  parameter logic [DATA_W-1:0] SP_LIMIT = 32'h0000_F000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              push,
  input  logic              pop,
  output logic [DATA_W-1:0] sp,
  output logic              sp_err
);

  // User write wins; lone push/pop moves SP unless it would cross a bound.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp     <= SP_RESET;
      sp_err <= 1'b0;
    end else if (wr_en) begin
      sp     <= wr_data;
      sp_err <= 1'b0;
    end else if (push && !pop) begin
      if (sp == SP_LIMIT) sp_err <= 1'b1;
      else                sp     <= sp - DATA_W'(1);
    end else if (pop && !push) begin
      if (sp == SP_RESET) sp_err <= 1'b1;
      else                sp     <= sp + DATA_W'(1);
    end
  end

endmodule

// File: rtl/special_reg_bank.sv
// SCC special-register bank: ZR, R1-R3, SP, LR, PC, CPSR.
module special_reg_bank
  import scc_pkg::*;
#(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       PC_STEP  = 1,
  parameter logic [DATA_W-1:0] PC_RESET = '0,
  parameter logic [DATA_W-1:0] SP_RESET = 32'h0000_FFFF,
  parameter logic [DATA_W-1:0] SP_LIMIT = 32'h0000_F000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              usr_wr_en,
  input  logic [2:0]        usr_wr_addr,
  input  logic [DATA_W-1:0] usr_wr_data,
  input  logic [2:0]        usr_rd_addr,
  output logic [DATA_W-1:0] usr_rd_data,
  input  logic              pc_inc,
  input  logic              pc_load,
  input  logic [DATA_W-1:0] pc_load_data,
  input  logic              pc_link,
  input  logic              sp_push,
  input  logic              sp_pop,
  input  logic [3:0]        flags_we,
  input  logic [3:0]        flags_in,
  output logic [DATA_W-1:0] zr_out,
  output logic [DATA_W-1:0] r1_out,
  output logic [DATA_W-1:0] r2_out,
  output logic [DATA_W-1:0] r3_out,
  output logic [DATA_W-1:0] sp_out,
  output logic [DATA_W-1:0] lr_out,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] cpsr_out,
  output logic              sp_err
);

  localparam int unsigned FLAG_LSB = DATA_W - NUM_FLAGS;

  logic [DATA_W-1:0] r1_q, r2_q, r3_q, lr_q, pc_q, cpsr_q;
  logic [DATA_W-1:0] r1_n, r2_n, r3_n, lr_n, pc_n, cpsr_n;
  logic [DATA_W-1:0] pc_plus;
  logic              wr_sp;
  flags_t            fl_we, fl_in;

  assign fl_we   = flags_we;
  assign fl_in   = flags_in;
  assign pc_plus = pc_q + DATA_W'(PC_STEP);
  assign wr_sp   = usr_wr_en && (usr_wr_addr == REG_SP);

  sp_ctrl #(
    .DATA_W   (DATA_W),
    .SP_RESET (SP_RESET),
    .SP_LIMIT (SP_LIMIT)
  ) u_sp_ctrl (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_sp),
    .wr_data (usr_wr_data),
    .push    (sp_push),
    .pop     (sp_pop),
    .sp      (sp_out),
    .sp_err  (sp_err)
  );

  // Next-state selection with per-register priority; ALU flags override user CPSR bits.
  always_comb begin
    r1_n   = r1_q;
    r2_n   = r2_q;
    r3_n   = r3_q;
    lr_n   = lr_q;
    pc_n   = pc_q;
    cpsr_n = cpsr_q;

    if (usr_wr_en) begin
      case (usr_wr_addr)
        REG_R1:   r1_n   = usr_wr_data;
        REG_R2:   r2_n   = usr_wr_data;
        REG_R3:   r3_n   = usr_wr_data;
        REG_LR:   lr_n   = usr_wr_data;
        REG_PC:   pc_n   = usr_wr_data;
        REG_CPSR: cpsr_n = usr_wr_data;
        default:  ;
      endcase
    end

    if (pc_load) begin
      pc_n = pc_load_data;
      if (pc_link) lr_n = pc_plus;
    end else if (!(usr_wr_en && usr_wr_addr == REG_PC) && pc_inc) begin
      pc_n = pc_plus;
    end

    for (int i = 0; i < int'(NUM_FLAGS); i++) begin
      if (fl_we[i]) cpsr_n[FLAG_LSB + i] = fl_in[i];
    end
  end

  // Register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r1_q   <= '0;
      r2_q   <= '0;
      r3_q   <= '0;
      lr_q   <= '0;
      pc_q   <= PC_RESET;
      cpsr_q <= '0;
    end else begin
      r1_q   <= r1_n;
      r2_q   <= r2_n;
      r3_q   <= r3_n;
      lr_q   <= lr_n;
      pc_q   <= pc_n;
      cpsr_q <= cpsr_n;
    end
  end

  // Combinational user read port; ZR is hard-wired to zero.
  always_comb begin
    usr_rd_data = '0;
    case (usr_rd_addr)
      REG_R1:   usr_rd_data = r1_q;
      REG_R2:   usr_rd_data = r2_q;
      REG_R3:   usr_rd_data = r3_q;
      REG_SP:   usr_rd_data = sp_out;
      REG_LR:   usr_rd_data = lr_q;
      REG_PC:   usr_rd_data = pc_q;
      REG_CPSR: usr_rd_data = cpsr_q;
      default:  usr_rd_data = '0;
    endcase
  end

  assign zr_out   = '0;
  assign r1_out   = r1_q;
  assign r2_out   = r2_q;
  assign r3_out   = r3_q;
  assign lr_out   = lr_q;
  assign pc_out   = pc_q;
  assign cpsr_out = cpsr_q;

endmodule

// File: tb/tb_special_reg_bank.sv
// Directed self-checking bench for special_reg_bank.
module tb_special_reg_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        usr_wr_en;
  logic [2:0]  usr_wr_addr;
  logic [31:0] usr_wr_data;
  logic [2:0]  usr_rd_addr;
  logic [31:0] usr_rd_data;
  logic        pc_inc, pc_load, pc_link, sp_push, sp_pop;
  logic [31:0] pc_load_data;
  logic [3:0]  flags_we, flags_in;
  logic [31:0] zr_out, r1_out, r2_out, r3_out, sp_out, lr_out, pc_out, cpsr_out;
  logic        sp_err;

  int n_cmp = 0;
  int n_bad = 0;

  special_reg_bank dut (
    .clk          (clk),
    .rst          (rst),
    .usr_wr_en    (usr_wr_en),
    .usr_wr_addr  (usr_wr_addr),
    .usr_wr_data  (usr_wr_data),
    .usr_rd_addr  (usr_rd_addr),
    .usr_rd_data  (usr_rd_data),
    .pc_inc       (pc_inc),
    .pc_load      (pc_load),
    .pc_load_data (pc_load_data),
    .pc_link      (pc_link),
    .sp_push      (sp_push),
    .sp_pop       (sp_pop),
    .flags_we     (flags_we),
    .flags_in     (flags_in),
    .zr_out       (zr_out),
    .r1_out       (r1_out),
    .r2_out       (r2_out),
    .r3_out       (r3_out),
    .sp_out       (sp_out),
    .lr_out       (lr_out),
    .pc_out       (pc_out),
    .cpsr_out     (cpsr_out),
    .sp_err       (sp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b0; usr_wr_en = 1'b0; usr_wr_addr = 3'd0; usr_wr_data = '0;
    pc_inc = 1'b0; pc_load = 1'b0; pc_link = 1'b0; pc_load_data = '0;
    sp_push = 1'b0; sp_pop = 1'b0; flags_we = 4'h0; flags_in = 4'h0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic uwr(input logic [2:0] a, input logic [31:0] d);
    usr_wr_en = 1'b1; usr_wr_addr = a; usr_wr_data = d;
  endtask

  initial begin
    idle();
    usr_rd_addr = 3'd0;
    rst = 1'b1;
    step();
    check("rst_pc",   pc_out,   32'h0);
    check("rst_sp",   sp_out,   32'h0000_FFFF);
    check("rst_cpsr", cpsr_out, 32'h0);
    check("rst_err",  32'(sp_err), 32'h0);
    check("rst_lr",   lr_out,   32'h0);
    check("rst_r1",   r1_out,   32'h0);

    // zero register ignores writes
    uwr(3'd0, 32'hDEAD_BEEF); step();
    usr_rd_addr = 3'd0; #1;
    check("zr_tap", zr_out, 32'h0);
    check("zr_rd",  usr_rd_data, 32'h0);

    // read-during-write returns the old value
    uwr(3'd1, 32'h1234_5678); usr_rd_addr = 3'd1; #1;
    check("r1_rdw_old", usr_rd_data, 32'h0);
    step();
    check("r1_rd_new", usr_rd_data, 32'h1234_5678);
    uwr(3'd3, 32'h0000_0C3C); step();
    check("r3_tap", r3_out, 32'h0000_0C3C);
    check("r2_tap", r2_out, 32'h0);

    // PC increment, branch with link, wrap
    for (int i = 0; i < 3; i++) begin
      pc_inc = 1'b1; step();
    end
    check("pc_inc3", pc_out, 32'h3);
    pc_load = 1'b1; pc_load_data = 32'h100; pc_link = 1'b1; pc_inc = 1'b1; step();
    check("bl_pc", pc_out, 32'h100);
    check("bl_lr", lr_out, 32'h4);
    pc_link = 1'b1; step();
    check("link_noload_lr", lr_out, 32'h4);
    uwr(3'd6, 32'hFFFF_FFFF); step();
    check("pc_preset", pc_out, 32'hFFFF_FFFF);
    pc_inc = 1'b1; step();
    check("pc_wrap", pc_out, 32'h0);

    // stack bounds
    sp_pop = 1'b1; step();
    check("pop_underflow_sp",  sp_out, 32'h0000_FFFF);
    check("pop_underflow_err", 32'(sp_err), 32'h1);
    sp_pop = 1'b1; step();
    check("err_sticky", 32'(sp_err), 32'h1);
    uwr(3'd4, 32'h0000_F001); step();
    check("sp_wr",    sp_out, 32'h0000_F001);
    check("sp_wr_clr", 32'(sp_err), 32'h0);
    sp_push = 1'b1; step();
    check("push1_sp",  sp_out, 32'h0000_F000);
    check("push1_err", 32'(sp_err), 32'h0);
    sp_push = 1'b1; step();
    check("push2_sp",  sp_out, 32'h0000_F000);
    check("push2_err", 32'(sp_err), 32'h1);
    uwr(3'd4, 32'h0000_F800); step();
    sp_push = 1'b1; sp_pop = 1'b1; step();
    check("pushpop_sp",  sp_out, 32'h0000_F800);
    check("pushpop_err", 32'(sp_err), 32'h0);
    sp_pop = 1'b1; step();
    check("pop_sp", sp_out, 32'h0000_F801);

    // flag merge
    uwr(3'd7, 32'h0000_00A5); flags_we = 4'b1010; flags_in = 4'b1111; step();
    check("flag_merge", cpsr_out, 32'hA000_00A5);
    flags_we = 4'b0001; flags_in = 4'b0000; step();
    check("flag_v_clr", cpsr_out, 32'hA000_00A5);
    flags_we = 4'b1100; flags_in = 4'b0100; step();
    check("flag_nz", cpsr_out, 32'h6000_00A5);
    uwr(3'd7, 32'hF000_0001); flags_we = 4'b0001; flags_in = 4'b0000; step();
    check("flag_over_usr", cpsr_out, 32'hE000_0001);

    // priority collisions
    uwr(3'd6, 32'h50); pc_inc = 1'b1; step();
    check("usr_pc_vs_inc", pc_out, 32'h50);
    uwr(3'd6, 32'h60); pc_load = 1'b1; pc_load_data = 32'h70; step();
    check("load_vs_usr_pc", pc_out, 32'h70);
    uwr(3'd5, 32'h999); pc_load = 1'b1; pc_load_data = 32'h200; pc_link = 1'b1; step();
    check("link_vs_usr_lr", lr_out, 32'h71);
    uwr(3'd5, 32'h999); pc_load = 1'b1; pc_load_data = 32'h300; step();
    check("usr_lr_nolink", lr_out, 32'h999);
    uwr(3'd4, 32'h8000); sp_push = 1'b1; step();
    check("usr_sp_vs_push", sp_out, 32'h8000);

    // reset wins over everything
    rst = 1'b1; pc_load = 1'b1; pc_load_data = 32'h1234; sp_push = 1'b1;
    flags_we = 4'hF; flags_in = 4'hF; uwr(3'd1, 32'h5555_5555);
    step();
    usr_rd_addr = 3'd7; #1;
    check("mid_rst_pc",   pc_out,   32'h0);
    check("mid_rst_sp",   sp_out,   32'h0000_FFFF);
    check("mid_rst_cpsr", cpsr_out, 32'h0);
    check("mid_rst_r1",   r1_out,   32'h0);
    check("mid_rst_r3",   r3_out,   32'h0);
    check("mid_rst_lr",   lr_out,   32'h0);
    check("mid_rst_err",  32'(sp_err), 32'h0);
    check("mid_rst_rd",   usr_rd_data, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/special_reg_bank.md
Name: special_reg_bank

Overview:
- Parametrised successor to the SCC special-register file (ZR, R1-R3, SP, LR, PC, CPSR).
- Keeps the user single-write/single-read port and the direct read taps. Adds synchronous reset values, a hard-wired zero register, PC increment/branch with link, SP push/pop with bound checking, and masked NZCV flag updates.
- Sits beside the general register file. Driven by the decode/control unit and the ALU flag outputs.

Parameters:
- DATA_W, 32, register width.
- PC_STEP, 1, PC increment per instruction (word-addressed).
- PC_RESET, 0, PC value after reset.
- SP_RESET, 32'h0000_FFFF, SP after reset; this is also the empty-stack (top) bound.
- SP_LIMIT, 32'h0000_F000, lowest legal SP; the full-stack bound.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- usr_wr_en  in  1  user write enable.
- usr_wr_addr  in  3  user write index (0=ZR 1-3=R1-R3 4=SP 5=LR 6=PC 7=CPSR).
- usr_wr_data  in  DATA_W  user write data.
- usr_rd_addr  in  3  user read index.
- usr_rd_data  out  DATA_W  combinational read of regs[usr_rd_addr].
- pc_inc  in  1  advance PC by PC_STEP.
- pc_load  in  1  branch: PC <= pc_load_data.
- pc_load_data  in  DATA_W  branch target.
- pc_link  in  1  with pc_load: LR <= PC + PC_STEP (BL).
- sp_push  in  1  SP <= SP - 1.
- sp_pop  in  1  SP <= SP + 1.
- flags_we  in  4  per-flag write mask {N,Z,C,V}.
- flags_in  in  4  new {N,Z,C,V}.
- zr_out, r1_out, r2_out, r3_out, sp_out, lr_out, pc_out, cpsr_out  out  DATA_W each  direct register taps.
- sp_err  out  1  sticky stack overflow/underflow flag.

Behaviour:
- Reset: when rst is high at a posedge, the following load and all other inputs are ignored that cycle:
  - ZR, R1-R3, LR, CPSR <= 0.
  - SP <= SP_RESET.
  - PC <= PC_RESET.
  - sp_err <= 0.
- Reads are combinational from current state. A read during a write to the same register returns the old value; the new value is visible the cycle after.
- ZR reads 0 at all times. Writes to it are discarded.
- R1-R3 are written only by the user port.
- PC priority, highest first: pc_load > usr write to PC > pc_inc > hold.
  - Increment wraps modulo 2^DATA_W.
- LR priority: pc_load&&pc_link > usr write to LR > hold.
  - Link value is the pre-update PC + PC_STEP, wrapping.
  - pc_link without pc_load has no effect.
- SP priority: usr write to SP > push/pop > hold.
  - A usr write to SP also clears sp_err.
  - push&&pop in the same cycle: SP holds, no error.
  - Push when SP == SP_LIMIT: SP holds, sp_err <= 1 (overflow).
  - Pop when SP == SP_RESET: SP holds, sp_err <= 1 (underflow).
  - sp_err stays set until rst or a usr SP write.
- CPSR: flags occupy bits [DATA_W-1:DATA_W-4] as N,Z,C,V. Bits [DATA_W-5:0] are written only by the user port.
  - A usr write to CPSR applies first. Then each flag with flags_we[i]=1 overrides its bit with flags_in[i] in the same cycle, so the ALU wins on flag bits.
- A usr write to index 6 or 7 concurrent with a higher-priority channel loses silently, with no error indication.
- Single-cycle latency on every update path; no stalls, no handshakes.

Decomposition:
- Package scc_pkg holds:
  - Register index constants: REG_ZR=0, REG_R1..R3, REG_SP=4, REG_LR=5, REG_PC=6, REG_CPSR=7.
  - Flag bit offsets: FLAG_N, FLAG_Z, FLAG_C, FLAG_V.
  - A 4-bit flags typedef.
- One sub-module: sp_ctrl. It holds the SP register, push/pop arithmetic, bound checks and the sticky sp_err.
- PC/LR/CPSR logic stays inline in special_reg_bank.

Test Plan:
- Reset then idle: rst=1 for one cycle → pc_out=0, sp_out=0000_FFFF, cpsr_out=0, sp_err=0. Then usr write ZR=DEADBEEF → zr_out stays 0 and usr_rd_addr=0 reads 0.
- PC paths:
  - pc_inc for 3 cycles → pc_out=3.
  - Next cycle pc_load=1, pc_load_data=0x100, pc_link=1, pc_inc=1 → pc_out=0x100, lr_out=4.
  - Preset PC=FFFF_FFFF via usr write, then pc_inc → pc_out=0.
- Stack bounds:
  - pop at reset → sp_out=FFFF, sp_err=1.
  - usr write SP=F001 → sp_err=0.
  - push twice → first push SP=F000; second push SP=F000 and sp_err=1.
  - push&&pop together → SP unchanged.
- Flag merge: usr write CPSR=0000_00A5 together with flags_we=4'b1010, flags_in=4'b1111 → cpsr_out=A000_00A5. Next cycle flags_we=4'b0001, flags_in=0 → cpsr_out unchanged.
- Priority collisions:
  - usr write PC=0x50 with pc_inc → pc_out=0x50.
  - usr write PC=0x60 with pc_load=0x70 → pc_out=0x70.
  - usr write SP=0x8000 with push → sp_out=0x8000.
- Reset mid-operation: rst asserted with pc_load, sp_push, flags_we=4'hF and a usr write all active → every register equals its reset value next cycle.
